// File: rtl/uart_core_param.sv
// uart_core_param: full-duplex UART with TX and RX FIFOs, 16x-oversampled
// baud ticks, 5..8 data bits (LSB first), 1 or 2 stop bits and sticky
// error flags. Optional parity support is controlled by the macro
// UART_PARITY_EN. When it is defined, the PAR state, parity generation and
// parity checking are built in and selected by PARITY. When it is not
// defined, frames carry no parity bit and parity_err is tied to 0.
//
// Handshake semantics (all single-cycle strobes, sampled on posedge clk):
//   wr_uart pushes w_data when tx_full=0; rd_uart pops the word shown on
//   r_data when rx_empty=0. A push into a full FIFO or a pop from an empty
//   FIFO is dropped, unless the opposite operation happens in the same cycle.

module uart_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW-1:0] ONE = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    // A push on a full FIFO is allowed only when a pop frees the head slot
    // in the same cycle. A pop on an empty FIFO is allowed only when a push
    // happens in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && (!empty || push);
    assign dout    = mem[rptr];

    // Storage is cleared on reset so the head reads as 0 while the FIFO is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wptr] <= din;
        end
    end

    // Pointers and registered full/empty flags.
    // The flags change only when exactly one of push or pop takes effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) wptr <= wptr + ONE;
            if (do_pop)  rptr <= rptr + ONE;
            if (do_push && !do_pop) begin
                empty <= 1'b0;
                full  <= ((wptr + ONE) == rptr);
            end else if (do_pop && !do_push) begin
                full  <= 1'b0;
                empty <= ((rptr + ONE) == wptr);
            end
        end
    end
endmodule

module uart_core_param #(
    parameter int DBIT      = 8,
    parameter int STOP_BITS = 1,
    parameter int DVSR      = 163,
    parameter int FIFO_AW   = 2,
    parameter int PARITY    = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DBIT-1:0] w_data,
    input  logic            wr_uart,
    output logic            tx_full,
    output logic            tx,
    input  logic            rx,
    input  logic            rd_uart,
    output logic            rx_empty,
    output logic [DBIT-1:0] r_data,
    input  logic            clr_err,
    output logic            parity_err,
    output logic            frame_err,
    output logic            overrun
);
    localparam int TW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DVSR - 1);
    localparam logic [4:0]    STOP_LAST = 5'(16 * STOP_BITS - 1);
    localparam logic [2:0]    N_LAST    = 3'(DBIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

`ifdef UART_PARITY_EN
    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic par_of(input logic [DBIT-1:0] d);
        return (PARITY == 2) ? ~(^d) : (^d);
    endfunction
`else
    logic parity_cfg_unused;
    assign parity_cfg_unused = (PARITY != 0);
`endif

    // ---------------------------------------------------------------- ticks
    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);

    // Free-running oversample tick generator: one pulse every DVSR clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_cnt <= '0;
        else     tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end

    // ----------------------------------------------------------- TX side
    logic [DBIT-1:0] tx_fifo_dout;
    logic            tx_empty;
    logic            tx_pop;
    state_t          tx_state;
    logic [4:0]      tx_s;
    logic [2:0]      tx_n;
    logic [DBIT-1:0] tx_b;
    logic            tx_reg;
    logic            tx_next;
`ifdef UART_PARITY_EN
    logic            tx_par;
`endif

    uart_fifo #(.W(DBIT), .AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_uart),
        .pop   (tx_pop),
        .din   (w_data),
        .dout  (tx_fifo_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // A word is taken either from idle or at the last tick of the stop
    // period. The second case lets back-to-back words go out with no gap.
    // Both cases are aligned to a tick, so every bit lasts exactly 16 ticks.
    assign tx_pop = tick && !tx_empty &&
                    ((tx_state == S_IDLE) ||
                     ((tx_state == S_STOP) && (tx_s == STOP_LAST)));

    // Line level that belongs to the current TX state.
    always_comb begin
        tx_next = 1'b1;
        case (tx_state)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = tx_b[0];
`ifdef UART_PARITY_EN
            S_PAR:   tx_next = tx_par;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    // TX frame sequencer. The tx pin is registered one clock behind the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_s     <= '0;
            tx_n     <= '0;
            tx_b     <= '0;
            tx_reg   <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_reg <= tx_next;
            if (tick) begin
                case (tx_state)
                    S_IDLE: begin
                        if (tx_pop) begin
                            tx_b     <= tx_fifo_dout;
`ifdef UART_PARITY_EN
                            tx_par   <= par_of(tx_fifo_dout);
`endif
                            tx_s     <= '0;
                            tx_state <= S_START;
                        end
                    end
                    S_START: begin
                        if (tx_s == 5'd15) begin
                            tx_s     <= '0;
                            tx_n     <= '0;
                            tx_state <= S_DATA;
                        end else begin
                            tx_s <= tx_s + 5'd1;
                        end
                    end
                    S_DATA: begin
                        if (tx_s == 5'd15) begin
                            tx_s <= '0;
                            tx_b <= tx_b >> 1;
                            if (tx_n == N_LAST) begin
`ifdef UART_PARITY_EN
                                tx_state <= (PARITY != 0) ? S_PAR : S_STOP;
`else
                                tx_state <= S_STOP;
`endif
                            end else begin
                                tx_n <= tx_n + 3'd1;
                            end
                        end else begin
                            tx_s <= tx_s + 5'd1;
                        end
                    end
`ifdef UART_PARITY_EN
                    S_PAR: begin
                        if (tx_s == 5'd15) begin
                            tx_s     <= '0;
                            tx_state <= S_STOP;
                        end else begin
                            tx_s <= tx_s + 5'd1;
                        end
                    end
`endif
                    S_STOP: begin
                        if (tx_s == STOP_LAST) begin
                            tx_s <= '0;
                            if (tx_pop) begin
                                tx_b     <= tx_fifo_dout;
`ifdef UART_PARITY_EN
                                tx_par   <= par_of(tx_fifo_dout);
`endif
                                tx_state <= S_START;
                            end else begin
                                tx_state <= S_IDLE;
                            end
                        end else begin
                            tx_s <= tx_s + 5'd1;
                        end
                    end
                    default: tx_state <= S_IDLE;
                endcase
            end
        end
    end

    assign tx = tx_reg;

    // ----------------------------------------------------------- RX side
    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;
    state_t          rx_state;
    logic [3:0]      rx_s;
    logic [2:0]      rx_n;
    logic [DBIT-1:0] rx_b;
    logic            rx_push;
    logic            rx_full;
    logic            ferr_set;
    logic            ovr_set;
`ifdef UART_PARITY_EN
    logic            perr_set;
`endif

    // Two-flop synchronizer plus one delayed copy used to detect the start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX frame sequencer. Bits are sampled at mid-bit. The word push and the
    // error pulses are registered and take effect one clock after the stop sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= S_IDLE;
            rx_s     <= '0;
            rx_n     <= '0;
            rx_b     <= '0;
            rx_push  <= 1'b0;
            ferr_set <= 1'b0;
`ifdef UART_PARITY_EN
            perr_set <= 1'b0;
`endif
        end else begin
            rx_push  <= 1'b0;
            ferr_set <= 1'b0;
`ifdef UART_PARITY_EN
            perr_set <= 1'b0;
`endif
            case (rx_state)
                S_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_s     <= '0;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (rx_s == 4'd7) begin
                            // Mid start bit: a high line here means the low pulse was a glitch.
                            if (rx_sync) begin
                                rx_state <= S_IDLE;
                            end else begin
                                rx_s     <= '0;
                                rx_n     <= '0;
                                rx_state <= S_DATA;
                            end
                        end else begin
                            rx_s <= rx_s + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (rx_s == 4'd15) begin
                            rx_s <= '0;
                            rx_b <= {rx_sync, rx_b[DBIT-1:1]};
                            if (rx_n == N_LAST) begin
`ifdef UART_PARITY_EN
                                rx_state <= (PARITY != 0) ? S_PAR : S_STOP;
`else
                                rx_state <= S_STOP;
`endif
                            end else begin
                                rx_n <= rx_n + 3'd1;
                            end
                        end else begin
                            rx_s <= rx_s + 4'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                S_PAR: begin
                    if (tick) begin
                        if (rx_s == 4'd15) begin
                            rx_s     <= '0;
                            perr_set <= (rx_sync != par_of(rx_b));
                            rx_state <= S_STOP;
                        end else begin
                            rx_s <= rx_s + 4'd1;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        if (rx_s == 4'd15) begin
                            // Only the first stop bit is checked. The word is kept even when it is bad.
                            rx_s     <= '0;
                            rx_push  <= 1'b1;
                            ferr_set <= !rx_sync;
                            rx_state <= S_IDLE;
                        end else begin
                            rx_s <= rx_s + 4'd1;
                        end
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    uart_fifo #(.W(DBIT), .AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rd_uart),
        .din   (rx_b),
        .dout  (r_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // The FIFO accepts a push on full only when rd_uart frees a slot in the
    // same cycle. Any other push on full drops the word.
    assign ovr_set = rx_push && rx_full && !rd_uart;

    // Sticky error flags. A new error wins over clr_err in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (ferr_set)     frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (ovr_set)      overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
        end
    end

`ifdef UART_PARITY_EN
    // Sticky parity error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           parity_err <= 1'b0;
        else if (perr_set) parity_err <= 1'b1;
        else if (clr_err)  parity_err <= 1'b0;
    end
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: an 8-bit instance (loopback or driven rx) and a
// 5-bit, 2-stop-bit instance in permanent loopback, both with DVSR=2.
`timescale 1ns/1ps
module tb_uart_core_param;
  localparam int DVSR = 2;
  localparam int BP = 16 * DVSR;
`ifdef UART_PARITY_EN
  localparam int P_BITS = 1;
  logic par_flip = 1'b0;
`else
  localparam int P_BITS = 0;
`endif
  localparam int FRAME = (1 + 8 + P_BITS + 1) * BP;
  localparam int FRAME5 = (1 + 5 + 2) * BP;

  // ---------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] w_data = '0;
  logic wr_uart = 1'b0, rd_uart = 1'b0, clr_err = 1'b0;
  logic tx_full, tx, rx_empty, parity_err, frame_err, overrun;
  logic [7:0] r_data;
  logic loop = 1'b0, rx_drv = 1'b1, rx_line;
  assign rx_line = loop ? tx : rx_drv;

  logic [4:0] w_data5 = '0;
  logic wr5 = 1'b0, rd5 = 1'b0;
  logic tx_full5, tx5, rx_empty5, perr5, ferr5, ovr5;
  logic [4:0] r_data5;

  uart_core_param #(.DBIT(8), .STOP_BITS(1), .DVSR(DVSR), .FIFO_AW(2), .PARITY(1)) dut (
    .clk(clk), .rst(rst), .w_data(w_data), .wr_uart(wr_uart), .tx_full(tx_full),
    .tx(tx), .rx(rx_line), .rd_uart(rd_uart), .rx_empty(rx_empty), .r_data(r_data),
    .clr_err(clr_err), .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  uart_core_param #(.DBIT(5), .STOP_BITS(2), .DVSR(DVSR), .FIFO_AW(2), .PARITY(0)) dut5 (
    .clk(clk), .rst(rst), .w_data(w_data5), .wr_uart(wr5), .tx_full(tx_full5),
    .tx(tx5), .rx(tx5), .rd_uart(rd5), .rx_empty(rx_empty5), .r_data(r_data5),
    .clr_err(1'b0), .parity_err(perr5), .frame_err(ferr5), .overrun(ovr5)
  );

  // ---------------------------------------------------- scoreboard state
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // ---------------------------------------------------- driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Model: a write is accepted when the TX FIFO is not full.
  task automatic write_word(input logic [7:0] d);
    if (!tx_full) exp_q.push_back(d);
    w_data = d;
    wr_uart = 1'b1;
    step();
    wr_uart = 1'b0;
  endtask

  task automatic find_fall(output int t);
    int k = 0;
    while (tx !== 1'b0 && k < 100) begin
      step();
      k++;
    end
    t = cyc;
    if (tx !== 1'b0) begin
      n_checks++; n_fail++;
      $display("FAIL tx_start_timeout: tx=%b required 0 within 100 cycles", tx);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    rx_drv = 1'b0;
    wait_n(BP);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      wait_n(BP);
    end
`ifdef UART_PARITY_EN
    rx_drv = (^d) ^ par_flip;
    wait_n(BP);
`endif
    rx_drv = stop;
    wait_n(BP);
    rx_drv = 1'b1;
    wait_n(BP);
  endtask

  // Scoreboard consumer: pop the main RX FIFO and compare each word with the queue head.
  task automatic drain(input int budget);
    int waited = 0;
    logic [7:0] exp_w;
    while (exp_q.size() > 0 && waited < budget) begin
      if (!rx_empty) begin
        exp_w = exp_q.pop_front();
        n_checks++;
        if (r_data !== exp_w) begin
          n_fail++;
          $display("FAIL rx_word: r_data=%h required %h", r_data, exp_w);
        end
        rd_uart = 1'b1;
        step();
        rd_uart = 1'b0;
      end else begin
        step();
      end
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL rx_timeout: %0d words still expected, 0 received", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------------------------------------------- tests
  task automatic test_reset();
    wait_n(3);
    rst = 1'b0;
    step();
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_tx: %b required 1", tx); end
    n_checks++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL rst_tx_full: %b required 0", tx_full); end
    n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL rst_rx_empty: %b required 1", rx_empty); end
    n_checks++; if (r_data !== 8'h00) begin n_fail++; $display("FAIL rst_r_data: %h required 00", r_data); end
    n_checks++; if ({parity_err, frame_err, overrun} !== 3'b000) begin
      n_fail++; $display("FAIL rst_errs: %b required 000", {parity_err, frame_err, overrun}); end
    n_checks++; if (tx5 !== 1'b1) begin n_fail++; $display("FAIL rst_tx5: %b required 1", tx5); end
  endtask

  task automatic test_loopback();
    int t0;
    loop = 1'b1;
    exp_q.delete();
    write_word(8'hA5);
    find_fall(t0);
    write_word(8'h3C);
    write_word(8'hFF);
    write_word(8'h00);
    n_checks++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL tx_full_at_3: %b required 0", tx_full); end
    write_word(8'h81);
    n_checks++; if (tx_full !== 1'b1) begin n_fail++; $display("FAIL tx_full_at_4: %b required 1", tx_full); end
    write_word(8'h5A);
    n_checks++; if (tx_full !== 1'b1) begin n_fail++; $display("FAIL tx_full_drop: %b required 1", tx_full); end
    wait_until(t0 + FRAME - 1);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL frame_stop: tx=%b required 1", tx); end
    step();
    n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL frame_len: tx=%b required 0 at next start", tx); end
    drain(6 * FRAME);
    wait_n(FRAME);
    n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL lb_extra_word: rx_empty=%b required 1", rx_empty); end
    n_checks++; if ({parity_err, frame_err, overrun} !== 3'b000) begin
      n_fail++; $display("FAIL lb_errs: %b required 000", {parity_err, frame_err, overrun}); end
    loop = 1'b0;
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    int t0;
    write_word(8'h07);
    exp_q.delete();
    find_fall(t0);
    wait_until(t0 + 9 * BP + BP / 2);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL tx_parity_bit: %b required 1", tx); end
    wait_until(t0 + FRAME + BP);
    par_flip = 1'b1;
    exp_q.push_back(8'h07);
    send_rx(8'h07, 1'b1);
    par_flip = 1'b0;
    n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL parity_err_set: %b required 1", parity_err); end
    drain(4 * FRAME);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_err_clr: %b required 0", parity_err); end
  endtask
`endif

  task automatic test_framing();
    exp_q.push_back(8'h55);
    send_rx(8'h55, 1'b0);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_err_set: %b required 1", frame_err); end
    n_checks++; if (rx_empty !== 1'b0) begin n_fail++; $display("FAIL frame_word_pushed: rx_empty=%b required 0", rx_empty); end
    drain(2 * FRAME);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL frame_err_clr: %b required 0", frame_err); end
    rx_drv = 1'b0;
    wait_n(4 * DVSR);
    rx_drv = 1'b1;
    wait_n(3 * BP);
    n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL glitch_push: rx_empty=%b required 1", rx_empty); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_err: frame_err=%b required 0", frame_err); end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom_range(0, 255));
      if (i < 4) exp_q.push_back(d);
      send_rx(d, 1'b1);
      if (i == 3) begin
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_early: %b required 0", overrun); end
      end
    end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: %b required 1", overrun); end
    n_checks++; if (rx_empty !== 1'b0) begin n_fail++; $display("FAIL overrun_rx_empty: %b required 0", rx_empty); end
    drain(2 * FRAME);
    n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL overrun_depth: rx_empty=%b required 1", rx_empty); end
    clr_err = 1'b1; step(); clr_err = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clr: %b required 0", overrun); end
  endtask

  task automatic test_reset_mid();
    int t0;
    loop = 1'b1;
    write_word(8'h00);
    find_fall(t0);
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    write_word(8'h44);
    n_checks++; if (tx_full !== 1'b1) begin n_fail++; $display("FAIL rm_full: %b required 1", tx_full); end
    wait_until(t0 + 3 * BP + BP / 2);
    n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL rm_tx_low: %b required 0", tx); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rm_async_tx: %b required 1", tx); end
    n_checks++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL rm_async_full: %b required 0", tx_full); end
    n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL rm_async_rx_empty: %b required 1", rx_empty); end
    wait_n(2);
    rst = 1'b0;
    wait_n(5);
    exp_q.delete();
    write_word(8'hC3);
    drain(3 * FRAME);
    n_checks++; if ({frame_err, overrun} !== 2'b00) begin
      n_fail++; $display("FAIL rm_errs: %b required 00", {frame_err, overrun}); end
    loop = 1'b0;
  endtask

  task automatic test_dbit5();
    int t0, k;
    logic [4:0] q5[$];
    logic [4:0] e5;
    q5.push_back(5'h1F);
    q5.push_back(5'h00);
    w_data5 = 5'h1F; wr5 = 1'b1; step();
    w_data5 = 5'h00; step();
    wr5 = 1'b0;
    k = 0;
    while (tx5 !== 1'b0 && k < 100) begin step(); k++; end
    t0 = cyc;
    n_checks++; if (tx5 !== 1'b0) begin n_fail++; $display("FAIL d5_start: tx5=%b required 0", tx5); end
    wait_until(t0 + FRAME5 - 1);
    n_checks++; if (tx5 !== 1'b1) begin n_fail++; $display("FAIL d5_stop2: tx5=%b required 1", tx5); end
    step();
    n_checks++; if (tx5 !== 1'b0) begin n_fail++; $display("FAIL d5_frame_len: tx5=%b required 0", tx5); end
    k = 0;
    while (q5.size() > 0 && k < 4 * FRAME5) begin
      if (!rx_empty5) begin
        e5 = q5.pop_front();
        n_checks++;
        if (r_data5 !== e5) begin n_fail++; $display("FAIL d5_word: r_data=%h required %h", r_data5, e5); end
        rd5 = 1'b1; step(); rd5 = 1'b0;
      end else begin
        step();
      end
      k++;
    end
    if (q5.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL d5_timeout: %0d words still expected, 0 received", q5.size());
    end
    n_checks++; if ({perr5, ferr5, ovr5} !== 3'b000) begin
      n_fail++; $display("FAIL d5_errs: %b required 000", {perr5, ferr5, ovr5}); end
  endtask

  // ---------------------------------------------------- sequence and report
  initial begin
    test_reset();
    test_loopback();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_framing();
    test_overrun();
    test_reset_mid();
    test_dbit5();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached before the test sequence completed");
    $fatal(1, "watchdog");
  end
endmodule
